// File: rtl/tp_ntt_pkg.sv
// Shared types and helpers for the TP-NTT pass scheduler: FSM states, sizing helpers and
// default pipeline latencies.
package tp_ntt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StGap,
    StFin
  } sched_state_e;

  localparam int unsigned DEF_BTF_LAT = 8;
  localparam int unsigned DEF_RD_LAT  = 2;
  localparam int unsigned DEF_AG_LAT  = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int unsigned depth(input int unsigned n, input int unsigned tp);
    return n / tp;
  endfunction

endpackage

// File: rtl/tp_ntt_delay_line.sv
// 1-bit shift-register delay of LEN cycles; LEN=0 passes the input straight through.
module tp_ntt_delay_line #(
  parameter int unsigned LEN = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  if (LEN == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = i_clk ^ i_rst;
    assign o_q      = i_d;
  end else if (LEN == 1) begin : g_one
    logic r_q;
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_q <= 1'b0;
      end else begin
        r_q <= i_d;
      end
    end
    assign o_q = r_q;
  end else begin : g_sr
    logic [LEN-1:0] r_sr;
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_sr <= '0;
      end else begin
        r_sr <= {r_sr[LEN-2:0], i_d};
      end
    end
    assign o_q = r_sr[LEN-1];
  end

endmodule

// File: rtl/ntt_pass_sched.sv
// Multi-pass TP-NTT scheduler: issues DEPTH address-generator starts per pass, aligns read and
// write strobes through delay lines, ping-pongs banks. TP_NTT_SCHED_CYCLE_CNT_EN adds cyc_count.
module ntt_pass_sched
  import tp_ntt_pkg::*;
#(
  parameter int unsigned N        = 128,
  parameter int unsigned TP       = 8,
  parameter int unsigned n2       = 2,
  parameter int unsigned BTF_LAT  = DEF_BTF_LAT,
  parameter int unsigned RD_LAT   = DEF_RD_LAT,
  parameter int unsigned AG_LAT   = DEF_AG_LAT,
  localparam int unsigned STAGE_W = (n2 > 1) ? clog2(n2) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               bank_sel,
  output logic               agen_start,
  output logic               rd_en,
  output logic               wr_en,
`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
  output logic [31:0]        cyc_count,
`endif
  output logic               wr_last
);

  localparam int unsigned DEPTH  = depth(N, TP);
  localparam int unsigned CTR_W  = clog2(DEPTH);
  localparam int unsigned WR_LAT = RD_LAT + BTF_LAT;

  sched_state_e       r_state;
  logic [CTR_W-1:0]   r_issue_ctr;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [STAGE_W-1:0] r_stage;
  logic               r_bank;
  logic               r_agen;

  logic w_agen_last;
  logic w_rd_en;
  logic w_rd_last;
  logic w_wr_en;
  logic w_wr_last;
  logic w_last_stage;

  // Tag that rides alongside the final agen_start of a pass to mark the final write.
  assign w_agen_last  = r_agen && (r_issue_ctr == CTR_W'(DEPTH - 1));
  assign w_last_stage = (r_stage == STAGE_W'(n2 - 1));

  tp_ntt_delay_line #(.LEN(AG_LAT)) u_rd_dly (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (r_agen),
    .o_q   (w_rd_en)
  );

  tp_ntt_delay_line #(.LEN(AG_LAT)) u_rd_last_dly (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_agen_last),
    .o_q   (w_rd_last)
  );

  tp_ntt_delay_line #(.LEN(WR_LAT)) u_wr_dly (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_rd_en),
    .o_q   (w_wr_en)
  );

  tp_ntt_delay_line #(.LEN(WR_LAT)) u_wr_last_dly (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (w_rd_last),
    .o_q   (w_wr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_issue_ctr <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stage     <= '0;
      r_bank      <= 1'b0;
      r_agen      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StIssue;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_agen      <= 1'b1;
            r_issue_ctr <= '0;
            r_stage     <= '0;
            r_bank      <= 1'b0;
          end
        end
        StIssue: begin
          if (r_issue_ctr == CTR_W'(DEPTH - 1)) begin
            r_agen      <= 1'b0;
            r_issue_ctr <= '0;
            // Only reachable with every latency at zero: the pass ends as it is issued.
            if (w_wr_last) begin
              r_state <= w_last_stage ? StFin : StGap;
              r_done  <= w_last_stage;
            end else begin
              r_state <= StDrain;
            end
          end else begin
            r_issue_ctr <= r_issue_ctr + CTR_W'(1);
          end
        end
        StDrain: begin
          // wr_last is the last tag injected, so both lines are empty once it emerges.
          if (w_wr_last) begin
            r_state <= w_last_stage ? StFin : StGap;
            r_done  <= w_last_stage;
          end
        end
        StGap: begin
          r_state <= StIssue;
          r_stage <= r_stage + STAGE_W'(1);
          r_bank  <= ~r_bank;
          r_agen  <= 1'b1;
        end
        StFin: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_agen  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
  logic [31:0] r_cyc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cyc <= '0;
    end else if (r_state == StIdle && start) begin
      r_cyc <= '0;
    end else if (r_busy && (r_cyc != 32'hFFFF_FFFF)) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  assign cyc_count = r_cyc;
`endif

  assign ready      = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign stage      = r_stage;
  assign bank_sel   = r_bank;
  assign agen_start = r_agen;
  assign rd_en      = w_rd_en;
  assign wr_en      = w_wr_en;
  assign wr_last    = w_wr_last;

endmodule

// File: tb/tb_ntt_pass_sched.sv
// Bench for ntt_pass_sched: three configurations (default, n2=1, zero read/butterfly latency)
// share stimulus and are checked cycle by cycle against a timeline model of each job.
module tb_ntt_pass_sched;

  localparam int NI    = 3;
  localparam int DEPTH = 16;

  int AG_A [NI] = '{2, 2, 2};
  int WL_A [NI] = '{10, 10, 0};
  int N2_A [NI] = '{2, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  logic [NI-1:0] ready_w, busy_w, done_w, agen_w, rd_w, wr_w, last_w, bank_w, stage_w;
`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
  logic [31:0] cyc_w [NI];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int tcyc    = 0;

  bit         act [NI];
  int         kk  [NI];
  logic [8:0] exp_v [NI];

  always #5 clk = ~clk;

  ntt_pass_sched #(.N(128), .TP(8), .n2(2), .BTF_LAT(8), .RD_LAT(2), .AG_LAT(2)) u_dut_def (
    .clk(clk), .rst(rst), .start(start), .ready(ready_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .stage(stage_w[0:0]), .bank_sel(bank_w[0]), .agen_start(agen_w[0]),
    .rd_en(rd_w[0]), .wr_en(wr_w[0]),
`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
    .cyc_count(cyc_w[0]),
`endif
    .wr_last(last_w[0])
  );

  ntt_pass_sched #(.N(128), .TP(8), .n2(1), .BTF_LAT(8), .RD_LAT(2), .AG_LAT(2)) u_dut_n1 (
    .clk(clk), .rst(rst), .start(start), .ready(ready_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .stage(stage_w[1:1]), .bank_sel(bank_w[1]), .agen_start(agen_w[1]),
    .rd_en(rd_w[1]), .wr_en(wr_w[1]),
`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
    .cyc_count(cyc_w[1]),
`endif
    .wr_last(last_w[1])
  );

  ntt_pass_sched #(.N(128), .TP(8), .n2(2), .BTF_LAT(0), .RD_LAT(0), .AG_LAT(2)) u_dut_zl (
    .clk(clk), .rst(rst), .start(start), .ready(ready_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .stage(stage_w[2:2]), .bank_sel(bank_w[2]), .agen_start(agen_w[2]),
    .rd_en(rd_w[2]), .wr_en(wr_w[2]),
`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
    .cyc_count(cyc_w[2]),
`endif
    .wr_last(last_w[2])
  );

  function automatic int pass_len(input int i);
    return DEPTH + AG_A[i] + WL_A[i];
  endfunction

  function automatic int fin_off(input int i);
    return N2_A[i] * (pass_len(i) + 1);
  endfunction

  // {ready, busy, done, agen, rd, wr, wr_last, bank, stage}; bank/stage only while busy.
  function automatic logic [8:0] model_out(input int i);
    int p, j, k, plen, lat;
    logic [8:0] v;
    v = 9'b1_0000_0000;
    if (act[i]) begin
      plen = pass_len(i);
      lat  = AG_A[i] + WL_A[i];
      k    = kk[i];
      p    = (k - 1) / (plen + 1);
      j    = (k - 1) % (plen + 1);
      v[8] = 1'b0;
      v[7] = 1'b1;
      v[6] = (k == fin_off(i));
      v[5] = (j < DEPTH);
      v[4] = (j >= AG_A[i]) && (j < AG_A[i] + DEPTH);
      v[3] = (j >= lat) && (j < lat + DEPTH);
      v[2] = (j == plen - 1);
      v[1] = (p % 2 == 1);
      v[0] = (p % 2 == 1);
    end
    return v;
  endfunction

  function automatic logic [8:0] obs(input int i);
    return {ready_w[i], busy_w[i], done_w[i], agen_w[i], rd_w[i], wr_w[i], last_w[i],
            busy_w[i] & bank_w[i], busy_w[i] & stage_w[i]};
  endfunction

  // Advance one clock; the model consumes the inputs that the edge samples.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        kk[i] = kk[i] + 1;
        if (kk[i] > fin_off(i)) act[i] = 1'b0;
      end else if (start) begin
        act[i] = 1'b1;
        kk[i]  = 1;
      end
    end
    @(negedge clk);
    tcyc = tcyc + 1;
    for (int i = 0; i < NI; i++) exp_v[i] = model_out(i);
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst   = 1'b0;
    cycle();
    rst   = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if ({obs(i), stage_w[i], bank_w[i]} !== 11'b1_0000_0000_00) begin
          n_fail++;
          $display("FAIL reset dut%0d cyc %0d: got %b required %b", i, tcyc,
                   {obs(i), stage_w[i], bank_w[i]}, 11'b1_0000_0000_00);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_pass_timing();
    int n_done, done_at;
    n_done  = 0;
    done_at = -1;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (obs(i) !== exp_v[i]) begin
          n_fail++;
          $display("FAIL timing dut%0d cyc %0d: got %b required %b", i, c, obs(i), exp_v[i]);
        end
      end
      if (done_w[0]) begin
        n_done++;
        done_at = c;
      end
      if (c == 29) begin
        n_tests++;
        if ({busy_w[0], agen_w[0]} !== 2'b10) begin
          n_fail++;
          $display("FAIL gap cyc 29: busy,agen got %b required 10", {busy_w[0], agen_w[0]});
        end
      end
      if (c == 30) begin
        n_tests++;
        if ({agen_w[0], stage_w[0], bank_w[0]} !== 3'b111) begin
          n_fail++;
          $display("FAIL pass1 cyc 30: agen,stage,bank got %b required 111",
                   {agen_w[0], stage_w[0], bank_w[0]});
        end
      end
      if (c == 59) begin
        n_tests++;
        if (ready_w[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_after_done cyc 59: got %b required 1", ready_w[0]);
        end
      end
      cycle();
    end
    n_tests++;
    if (n_done !== 1 || done_at !== 58) begin
      n_fail++;
      $display("FAIL done_pulse: count %0d at %0d, required 1 at 58", n_done, done_at);
    end
  endtask

  task automatic test_n2_one();
    int n_rd, n_wr, n_done, n_bank;
    n_rd = 0; n_wr = 0; n_done = 0; n_bank = 0;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      n_tests++;
      if (obs(1) !== exp_v[1]) begin
        n_fail++;
        $display("FAIL n2_one cyc %0d: got %b required %b", c, obs(1), exp_v[1]);
      end
      n_rd   += int'(rd_w[1]);
      n_wr   += int'(wr_w[1]);
      n_done += int'(done_w[1]);
      n_bank += int'(bank_w[1]);
      cycle();
    end
    n_tests++;
    if ({n_rd, n_wr, n_done, n_bank} !== {32'd16, 32'd16, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL n2_one_counts: rd %0d wr %0d done %0d bank %0d, required 16 16 1 0",
               n_rd, n_wr, n_done, n_bank);
    end
  endtask

  task automatic test_zero_latency();
    int last_at;
    last_at = -1;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      n_tests++;
      if (obs(2) !== exp_v[2] || rd_w[2] !== wr_w[2]) begin
        n_fail++;
        $display("FAIL zero_lat cyc %0d: got %b rd %b wr %b required %b", c, obs(2), rd_w[2],
                 wr_w[2], exp_v[2]);
      end
      if (last_w[2] && last_at < 0) last_at = c;
      cycle();
    end
    n_tests++;
    if (last_at !== 18) begin
      n_fail++;
      $display("FAIL zero_lat_pass_len: first wr_last at %0d required 18", last_at);
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int dn [2];
    int na, nd;
    na = 0; nd = 0;
    do_reset();
    start = 1'b1;
    cycle();
    for (int c = 1; c <= 125; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (obs(i) !== exp_v[i] || ready_w[i] === busy_w[i]) begin
          n_fail++;
          $display("FAIL b2b dut%0d cyc %0d: got %b required %b", i, c, obs(i), exp_v[i]);
        end
      end
      if (ready_w[0] && na < 2) begin acc[na] = c; na++; end
      if (done_w[0] && nd < 2) begin dn[nd] = c; nd++; end
      cycle();
    end
    start = 1'b0;
    n_tests++;
    if (na !== 2 || nd !== 2 || acc[0] !== dn[0] + 1 || acc[1] !== dn[1] + 1 ||
        dn[0] !== 58) begin
      n_fail++;
      $display("FAIL b2b_accept: accepts %0d dones %0d first done %0d accept %0d",
               na, nd, (nd > 0) ? dn[0] : -1, (na > 0) ? acc[0] : -1);
    end
  endtask

  task automatic test_mid_reset();
    int n_done;
    n_done = 0;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (obs(i) !== exp_v[i]) begin
          n_fail++;
          $display("FAIL mid_reset dut%0d cyc %0d: got %b required %b", i, c, obs(i), exp_v[i]);
        end
        if (c == 21) begin
          n_tests++;
          if (obs(i) !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL mid_reset_abort dut%0d: got %b required 100000000", i, obs(i));
          end
        end
      end
      n_done += int'(done_w[0]);
      rst = (c != 20);
      cycle();
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 62; c++) begin
      n_tests++;
      if (obs(0) !== exp_v[0]) begin
        n_fail++;
        $display("FAIL rerun cyc %0d: got %b required %b", c, obs(0), exp_v[0]);
      end
      if (done_w[0]) begin
        n_tests++;
        if (c !== 58) begin
          n_fail++;
          $display("FAIL rerun_done: at %0d required 58", c);
        end
      end
      cycle();
    end
    n_tests++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d done pulses required 0", n_done);
    end
  endtask

`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
  task automatic test_cyc_count();
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 72; c++) begin
      n_tests++;
      if (c <= 59 && cyc_w[0] !== 32'(c - 1)) begin
        n_fail++;
        $display("FAIL cyc_count cyc %0d: got %0d required %0d", c, cyc_w[0], c - 1);
      end else if (c > 59 && c <= 71 && cyc_w[0] !== 32'd58) begin
        n_fail++;
        $display("FAIL cyc_count_hold cyc %0d: got %0d required 58", c, cyc_w[0]);
      end else if (c == 72 && cyc_w[0] !== 32'd0) begin
        n_fail++;
        $display("FAIL cyc_count_clear: got %0d required 0", cyc_w[0]);
      end
      start = (c == 71);
      cycle();
    end
    start = 1'b0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (obs(i) !== exp_v[i]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d: got %b required %b", i, c, obs(i), exp_v[i]);
        end
      end
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 249) != 0);
      cycle();
    end
    rst   = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0;
      kk[i]  = 0;
    end
    test_reset();
    test_pass_timing();
    test_n2_one();
    test_zero_latency();
    test_back_to_back();
    test_mid_reset();
`ifdef TP_NTT_SCHED_CYCLE_CNT_EN
    test_cyc_count();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
